// File: rtl/ai_accel_pkg.sv
// rtl/ai_accel_pkg.sv - shared word offsets, opcodes, status bits and FSM states for the matmul accelerator
package ai_accel_pkg;

    localparam logic [9:0] REG_OP  = 10'd0;
    localparam logic [9:0] REG_W_A = 10'd1;
    localparam logic [9:0] REG_H_A = 10'd2;
    localparam logic [9:0] REG_W_B = 10'd3;
    localparam logic [9:0] REG_H_B = 10'd4;
    localparam logic [9:0] REG_GO  = 10'd5;
    localparam logic [9:0] A_BASE  = 10'd6;

    localparam logic [31:0] OP_MATMUL = 32'd1;

    localparam int ST_BUSY  = 0;
    localparam int ST_DONE  = 1;
    localparam int ST_ERROR = 2;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_MAC   = 2'd1,
        S_STORE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    function automatic logic dim_ok(input logic [31:0] d, input int max_dim);
        return (d != 32'd0) && (d <= 32'(max_dim));
    endfunction

endpackage

// File: rtl/ai_accel_mac.sv
// rtl/ai_accel_mac.sv - registered signed 32x32 multiply-accumulate with wrapping 32-bit accumulator
module ai_accel_mac (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_clr,
    input  logic        i_en,
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    output logic [31:0] o_acc
);

    logic signed [63:0] w_prod;
    logic        [31:0] r_acc;
    logic               w_unused;

    assign w_prod   = $signed({{32{i_a[31]}}, i_a}) * $signed({{32{i_b[31]}}, i_b});
    // Only the low word survives: the accumulator wraps modulo 2^32.
    assign w_unused = &{1'b0, w_prod[63:32]};
    assign o_acc    = r_acc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc <= '0;
        end else if (i_clr) begin
            r_acc <= '0;
        end else if (i_en) begin
            r_acc <= r_acc + w_prod[31:0];
        end
    end

endmodule

// File: rtl/ai_accelerator_top.sv
// rtl/ai_accelerator_top.sv - Wishbone-slave matrix multiply accelerator: bus decode, operand/result memories, sequencing FSM
module ai_accelerator_top
    import ai_accel_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h3010_0000,
    parameter int          MAX_DIM     = 4,
    parameter int          IN_MEM_SIZE = 64
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic [31:0] wb_addr_i,
    input  logic        wb_we_i,
    input  logic [31:0] wb_data_i,
    output logic [31:0] wb_data_o,
    output logic        wb_ack,
    input  logic        wb_stb
);

    localparam int DW = $clog2(MAX_DIM + 1);
    localparam int MW = $clog2(IN_MEM_SIZE);
    localparam int CN = MAX_DIM * MAX_DIM;
    localparam int CW = $clog2(CN);
    localparam logic [9:0] C_BASE = 10'(IN_MEM_SIZE);
    localparam logic [9:0] C_END  = 10'(IN_MEM_SIZE + CN);

    state_t         r_state, w_next_state;
    logic           r_ack;
    logic [31:0]    r_data_o;
    logic [31:0]    r_op, r_w_a, r_h_a, r_w_b, r_h_b;
    logic           r_done, r_error;
    logic [31:0]    r_in_mem [int'(A_BASE):IN_MEM_SIZE-1];
    logic [31:0]    r_c      [CN];
    logic [DW-1:0]  r_i, r_j, r_k;

    logic           w_hit, w_busy, w_accept, w_wr, w_go, w_go_ok;
    logic           w_in_mem, w_in_c, w_last_i, w_last_j, w_last_k;
    logic           w_mac_en, w_acc_clr, w_store, w_unused;
    logic [9:0]     w_word, w_c_off;
    logic [DW-1:0]  w_wa, w_ha, w_wb;
    logic [MW-1:0]  w_a_idx, w_b_idx;
    logic [CW-1:0]  w_c_idx;
    logic [31:0]    w_rdata, w_acc;

    assign w_hit    = (wb_addr_i[31:12] == BASE_ADDR[31:12]);
    assign w_word   = wb_addr_i[11:2] - BASE_ADDR[11:2];
    assign w_c_off  = w_word - C_BASE;
    assign w_busy   = (r_state == S_MAC) || (r_state == S_STORE);
    // The !r_ack term spaces acks so a master holding stb sees one every other cycle.
    assign w_accept = wb_stb && w_hit && !r_ack && !w_busy;
    assign w_wr     = w_accept && wb_we_i;
    assign w_go     = w_wr && (w_word == REG_GO);
    assign w_go_ok  = (r_op == OP_MATMUL) && (r_w_a == r_h_b) &&
                      dim_ok(r_w_a, MAX_DIM) && dim_ok(r_h_a, MAX_DIM) &&
                      dim_ok(r_w_b, MAX_DIM) && dim_ok(r_h_b, MAX_DIM);
    assign w_in_mem = (w_word >= A_BASE) && (w_word < C_BASE);
    assign w_in_c   = (w_word >= C_BASE) && (w_word < C_END);
    assign w_unused = &{1'b0, wb_addr_i[1:0], w_c_off[9:CW]};

    assign w_wa     = r_w_a[DW-1:0];
    assign w_ha     = r_h_a[DW-1:0];
    assign w_wb     = r_w_b[DW-1:0];
    assign w_last_k = (r_k == w_wa - DW'(1));
    assign w_last_j = (r_j == w_wb - DW'(1));
    assign w_last_i = (r_i == w_ha - DW'(1));
    assign w_a_idx  = MW'(A_BASE) + MW'(r_i) * MW'(w_wa) + MW'(r_k);
    assign w_b_idx  = MW'(A_BASE) + MW'(w_wa) * MW'(w_ha) + MW'(r_k) * MW'(w_wb) + MW'(r_j);
    assign w_c_idx  = CW'(r_i) * CW'(w_wb) + CW'(r_j);

    assign wb_ack    = r_ack;
    assign wb_data_o = r_data_o;

    ai_accel_mac u_mac (
        .clk   (wb_clk_i),
        .rst_n (wb_rst_i),
        .i_clr (w_acc_clr),
        .i_en  (w_mac_en),
        .i_a   (r_in_mem[w_a_idx]),
        .i_b   (r_in_mem[w_b_idx]),
        .o_acc (w_acc)
    );

    always_comb begin
        w_rdata = '0;
        if (w_word == REG_OP) begin
            w_rdata = r_op;
        end else if (w_word == REG_W_A) begin
            w_rdata = r_w_a;
        end else if (w_word == REG_H_A) begin
            w_rdata = r_h_a;
        end else if (w_word == REG_W_B) begin
            w_rdata = r_w_b;
        end else if (w_word == REG_H_B) begin
            w_rdata = r_h_b;
        end else if (w_word == REG_GO) begin
            w_rdata[ST_BUSY]  = w_busy;
            w_rdata[ST_DONE]  = r_done;
            w_rdata[ST_ERROR] = r_error;
        end else if (w_in_mem) begin
            w_rdata = r_in_mem[w_word[MW-1:0]];
        end else if (w_in_c) begin
            w_rdata = r_c[w_c_off[CW-1:0]];
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_mac_en     = 1'b0;
        w_acc_clr    = 1'b0;
        w_store      = 1'b0;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (w_go) begin
                    w_next_state = w_go_ok ? S_MAC : S_DONE;
                    w_acc_clr    = w_go_ok;
                end
            end
            S_MAC: begin
                w_mac_en = 1'b1;
                if (w_last_k) begin
                    w_next_state = S_STORE;
                end
            end
            S_STORE: begin
                w_store      = 1'b1;
                w_acc_clr    = 1'b1;
                w_next_state = (w_last_i && w_last_j) ? S_DONE : S_MAC;
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
            r_ack    <= 1'b0;
            r_data_o <= '0;
            r_op     <= '0;
            r_w_a    <= '0;
            r_h_a    <= '0;
            r_w_b    <= '0;
            r_h_b    <= '0;
            r_done   <= 1'b0;
            r_error  <= 1'b0;
            r_i      <= '0;
            r_j      <= '0;
            r_k      <= '0;
            for (int n = int'(A_BASE); n < IN_MEM_SIZE; n++) begin
                r_in_mem[n] <= '0;
            end
            for (int n = 0; n < CN; n++) begin
                r_c[n] <= '0;
            end
        end else begin
            r_ack <= w_accept;
            if (w_accept) begin
                r_data_o <= w_rdata;
            end
            if (w_wr) begin
                if (w_word == REG_OP)  r_op  <= wb_data_i;
                if (w_word == REG_W_A) r_w_a <= wb_data_i;
                if (w_word == REG_H_A) r_h_a <= wb_data_i;
                if (w_word == REG_W_B) r_w_b <= wb_data_i;
                if (w_word == REG_H_B) r_h_b <= wb_data_i;
                if (w_in_mem) begin
                    r_in_mem[w_word[MW-1:0]] <= wb_data_i;
                end
            end
            if (w_go) begin
                if (w_go_ok) begin
                    r_done  <= 1'b0;
                    r_error <= 1'b0;
                    r_i     <= '0;
                    r_j     <= '0;
                    r_k     <= '0;
                end else begin
                    // Unknown opcodes only report completion; a bad matmul setup also flags error.
                    r_done <= 1'b1;
                    if (r_op == OP_MATMUL) begin
                        r_error <= 1'b1;
                    end
                end
            end
            if (w_mac_en) begin
                r_k <= w_last_k ? '0 : r_k + 1'b1;
            end
            if (w_store) begin
                r_c[w_c_idx] <= w_acc;
                if (w_last_j) begin
                    r_j <= '0;
                    if (w_last_i) begin
                        r_i    <= '0;
                        r_done <= 1'b1;
                    end else begin
                        r_i <= r_i + 1'b1;
                    end
                end else begin
                    r_j <= r_j + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_ai_accelerator_top.sv
// tb/tb_ai_accelerator_top.sv - self-checking bench: word-map model, per-ack compare process, directed matmul scenarios
module tb_ai_accelerator_top;

    localparam logic [31:0] BASE = 32'h3010_0000;
    localparam int TIMEOUT = 200;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b1;
    logic        we    = 1'b0;
    logic        stb   = 1'b0;
    logic [31:0] addr  = '0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata;
    logic        ack;

    always #5 clk = ~clk;

    ai_accelerator_top #(
        .BASE_ADDR   (BASE),
        .MAX_DIM     (4),
        .IN_MEM_SIZE (64)
    ) dut (
        .wb_clk_i  (clk),
        .wb_rst_i  (rst_n),
        .wb_addr_i (addr),
        .wb_we_i   (we),
        .wb_data_i (wdata),
        .wb_data_o (rdata),
        .wb_ack    (ack),
        .wb_stb    (stb)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Word-map model: a GO resolves the whole product at once; the DUT withholds acks
    // while computing, so every read it acks must already match the final state.
    int m_ctrl [5];
    int m_mem  [64];
    int m_c    [16];
    bit m_done, m_err;
    int busy_left;

    function automatic void model_reset();
        foreach (m_ctrl[n]) m_ctrl[n] = 0;
        foreach (m_mem[n])  m_mem[n]  = 0;
        foreach (m_c[n])    m_c[n]    = 0;
        m_done    = 1'b0;
        m_err     = 1'b0;
        busy_left = 0;
    endfunction

    function automatic bit in_dim(int d);
        return d >= 1 && d <= 4;
    endfunction

    function automatic void model_go();
        int wa, ha, wb, s;
        wa = m_ctrl[1];
        ha = m_ctrl[2];
        wb = m_ctrl[3];
        if (m_ctrl[0] == 1 && wa == m_ctrl[4] && in_dim(wa) && in_dim(ha) && in_dim(wb) && in_dim(m_ctrl[4])) begin
            for (int i = 0; i < ha; i++) begin
                for (int j = 0; j < wb; j++) begin
                    s = 0;
                    for (int k = 0; k < wa; k++) begin
                        s += m_mem[6 + i*wa + k] * m_mem[6 + wa*ha + k*wb + j];
                    end
                    m_c[i*wb + j] = s;
                end
            end
            m_done    = 1'b1;
            m_err     = 1'b0;
            busy_left = ha * wb * (wa + 1);
        end else if (m_ctrl[0] == 1) begin
            m_done = 1'b1;
            m_err  = 1'b1;
        end else begin
            m_done = 1'b1;
        end
    endfunction

    function automatic void model_write(int w, logic [31:0] d);
        if (w < 5)       m_ctrl[w] = int'(d);
        else if (w == 5) model_go();
        else if (w < 64) m_mem[w] = int'(d);
    endfunction

    function automatic int model_read(int w);
        if (w < 5)  return m_ctrl[w];
        if (w == 5) return (int'(m_err) << 2) | (int'(m_done) << 1);
        if (w < 64) return m_mem[w];
        if (w < 80) return m_c[w - 64];
        return 0;
    endfunction

    logic [31:0] lat_addr, lat_data;
    logic        lat_we;
    logic        prev_ack = 1'b0;
    int          cmp_word;

    always @(posedge clk) begin
        lat_addr <= addr;
        lat_we   <= we;
        lat_data <= wdata;
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            check("reset_ack", {31'd0, ack}, 32'd0);
            check("reset_data", rdata, 32'd0);
            model_reset();
            prev_ack = 1'b0;
        end else begin
            if (prev_ack) check("ack_single_cycle", {31'd0, ack}, 32'd0);
            if (busy_left > 0) begin
                check("ack_while_busy", {31'd0, ack}, 32'd0);
                busy_left--;
            end
            if (ack) begin
                cmp_word = int'((lat_addr - BASE) >> 2);
                if (lat_we) model_write(cmp_word, lat_data);
                else        check("read_vs_model", rdata, 32'(model_read(cmp_word)));
            end
            prev_ack = ack;
        end
    end

    task automatic bus_access(input logic [31:0] a, input logic w, input logic [31:0] d,
                              output logic [31:0] rd_d, output int cyc);
        addr  = a;
        wdata = d;
        we    = w;
        stb   = 1'b1;
        cyc   = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!ack && cyc < TIMEOUT);
        rd_d = rdata;
        stb  = 1'b0;
        we   = 1'b0;
        if (!ack) check("bus_timeout", {31'd0, ack}, 32'd1);
    endtask

    task automatic wr(input int w, input logic [31:0] d);
        logic [31:0] dummy;
        int          c;
        bus_access(BASE + 32'(w * 4), 1'b1, d, dummy, c);
    endtask

    task automatic rd(input int w, output logic [31:0] d, output int cyc);
        bus_access(BASE + 32'(w * 4), 1'b0, 32'd0, d, cyc);
    endtask

    task automatic rd_expect(input string name, input int w, input logic [31:0] exp);
        logic [31:0] d;
        int          c;
        rd(w, d, c);
        check(name, d, exp);
    endtask

    task automatic set_dims(input int wa, input int ha, input int wb, input int hb);
        wr(0, 32'd1);
        wr(1, 32'(wa));
        wr(2, 32'(ha));
        wr(3, 32'(wb));
        wr(4, 32'(hb));
    endtask

    int a2 [4] = '{-3, -15, -6, 7};
    int b2 [4] = '{9, -15, -2, -5};
    int c2 [4] = '{3, 120, -68, 55};

    task automatic load_2x2();
        set_dims(2, 2, 2, 2);
        for (int n = 0; n < 4; n++) wr(6 + n, 32'(a2[n]));
        for (int n = 0; n < 4; n++) wr(10 + n, 32'(b2[n]));
    endtask

    logic [31:0] rv;
    int          rc;
    logic [5:0]  ack_pat;

    initial begin
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);

        rd_expect("reset_status", 5, 32'h0);
        rd_expect("reset_op", 0, 32'h0);
        rd_expect("reset_c0", 64, 32'h0);

        load_2x2();
        for (int n = 0; n < 4; n++) rd_expect("readback_a", 6 + n, 32'(a2[n]));
        for (int n = 0; n < 4; n++) rd_expect("readback_b", 10 + n, 32'(b2[n]));
        rd_expect("readback_w_a", 1, 32'd2);
        wr(5, 32'hFFFF_FFFF);
        rd(64, rv, rc);
        check("c00_after_stall", rv, 32'd3);
        check("go_stall_cycles", 32'(rc), 32'd13);
        for (int n = 1; n < 4; n++) rd_expect("c_2x2", 64 + n, 32'(c2[n]));
        rd_expect("status_done", 5, 32'h2);

        wr(4, 32'd3);
        wr(5, 32'd0);
        rd_expect("status_mismatch", 5, 32'h6);
        rd_expect("c00_kept_on_error", 64, 32'd3);
        wr(64, 32'h1234_5678);
        rd_expect("c_region_read_only", 64, 32'd3);

        set_dims(4, 4, 4, 4);
        for (int n = 0; n < 16; n++) wr(6 + n, (n / 4 == n % 4) ? 32'd1 : 32'd0);
        for (int n = 0; n < 16; n++) wr(22 + n, 32'(n * 1001 - 7000));
        wr(5, 32'd1);
        for (int n = 0; n < 16; n++) rd_expect("identity_times_m", 64 + n, 32'(n * 1001 - 7000));
        rd_expect("status_after_4x4", 5, 32'h2);

        set_dims(2, 1, 1, 2);
        wr(6, 32'h7FFF_FFFF);
        wr(7, 32'h7FFF_FFFF);
        wr(8, 32'd1);
        wr(9, 32'd1);
        wr(5, 32'd1);
        rd_expect("acc_wrap", 64, 32'hFFFF_FFFE);
        rd_expect("c1_kept_from_4x4", 65, 32'(1 * 1001 - 7000));

        wr(0, 32'd7);
        wr(5, 32'd0);
        rd_expect("status_noop_op", 5, 32'h2);

        set_dims(4, 4, 4, 4);
        wr(5, 32'd1);
        repeat (20) @(negedge clk);
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        rd_expect("status_after_abort", 5, 32'h0);
        rd_expect("c0_after_abort", 64, 32'h0);
        rd_expect("a0_after_abort", 6, 32'h0);

        load_2x2();
        wr(5, 32'd1);
        for (int n = 0; n < 4; n++) rd_expect("c_rerun", 64 + n, 32'(c2[n]));

        @(negedge clk);
        addr = BASE + 32'(64 * 4);
        we   = 1'b0;
        stb  = 1'b1;
        ack_pat = '0;
        for (int n = 0; n < 6; n++) begin
            @(negedge clk);
            ack_pat = {ack_pat[4:0], ack};
        end
        stb = 1'b0;
        check("held_stb_ack_pattern", {26'd0, ack_pat}, 32'b101010);

        rd(200, rv, rc);
        check("unmapped_read", rv, 32'h0);
        check("unmapped_acked", {31'd0, ack}, 32'd1);

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
